// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, the memory-stage FSM state type and the
// writeback boundary register layout for the pipelined CPU.
`timescale 1ns/1ps
package cpu_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WAIT_W     = 4;   // width of the memory wait-state counter

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // Memory/writeback pipeline register contents.
  typedef struct packed {
    logic                  reg_write;
    logic [WORD_W-1:0]     result;
    logic [REG_ADDR_W-1:0] write_reg;
    logic                  upper;
  } wb_reg_t;

endpackage

// File: rtl/data_ram.sv
// data_ram: MEM_WORDS x 32-bit data memory.
// Combinational read, synchronous write gated by we, contents not reset.
// Ports:
//   clk   - clock, writes land on posedge
//   we    - write enable
//   addr  - word index
//   wdata - write data
//   rdata - read data for addr (combinational)
`timescale 1ns/1ps
module data_ram
  import cpu_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the pipelined CPU.
// Performs word loads/stores against data_ram with WAIT_STATES extra cycles
// per access, stalls upstream while an access is in flight, and registers
// the result into the memory/writeback boundary.
// Optional feature: define MEM_ALIGN_CHECK_EN to add the sticky misalign_err
// output; misaligned stores are then dropped and misaligned loads return 0.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   reg_write_m       - instruction writes the register file
//   mem_to_reg_m      - load (wins over mem_write_m when both are set)
//   mem_write_m       - store
//   alu_result_m      - byte address for memory ops, else the ALU result
//   write_data_m      - store data
//   write_reg_m       - destination register
//   upper_m           - carried unchanged to writeback
//   stall_m           - combinational stall toward hazard logic
//   reg_write_w, result_w, write_reg_w, upper_w - registered WB outputs
//   misalign_err      - sticky misaligned-access flag (MEM_ALIGN_CHECK_EN)
//
// Stall protocol: stall_m is a hold request, not a valid/ready pair. While
// stall_m=1 the producer keeps every *_m input stable; the cycle in which
// stall_m=0 is the one where the instruction is accepted and its result is
// loaded into the WB register at the next edge. Stalled cycles load a bubble.
`timescale 1ns/1ps
module memory_stage
  import cpu_pkg::*;
#(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write_m,
  input  logic                  mem_to_reg_m,
  input  logic                  mem_write_m,
  input  logic [WORD_W-1:0]     alu_result_m,
  input  logic [WORD_W-1:0]     write_data_m,
  input  logic [REG_ADDR_W-1:0] write_reg_m,
  input  logic                  upper_m,
  output logic                  stall_m,
  output logic                  reg_write_w,
  output logic [WORD_W-1:0]     result_w,
  output logic [REG_ADDR_W-1:0] write_reg_w,
  output logic                  upper_w
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                  misalign_err
`endif
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam bit HAS_WAIT = (WAIT_STATES != 0);
  localparam logic [WAIT_W-1:0] CNT_INIT =
    WAIT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  // state_q is left as a plain named register so checkers can bind to it.
  mem_state_t        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  wb_reg_t           wb_q, wb_d;

  logic              mem_op;
  logic              is_load;
  logic              is_store;
  logic              commit;     // final cycle of a memory op
  logic              misalign;
  logic              ram_we;
  logic [AW-1:0]     word_addr;
  logic [WORD_W-1:0] ram_rdata;

  // Upper address bits alias (wrap) and byte-offset bits are not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{alu_result_m[WORD_W-1:AW+2], alu_result_m[1:0]};

  assign is_load   = mem_to_reg_m;
  assign is_store  = mem_write_m & ~mem_to_reg_m;
  assign mem_op    = mem_to_reg_m | mem_write_m;
  assign word_addr = alu_result_m[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (alu_result_m[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_m = 1'b0;
    commit  = 1'b0;
    wb_d    = '0;    // bubble unless something below loads the WB register
    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          wb_d.reg_write = reg_write_m;
          wb_d.result    = alu_result_m;
          wb_d.write_reg = write_reg_m;
          wb_d.upper     = upper_m;
        end else if (HAS_WAIT) begin
          stall_m = 1'b1;
          state_d = ACCESS;
          cnt_d   = CNT_INIT;
        end else begin
          commit = 1'b1;   // zero wait states: the first cycle is the final one
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          stall_m = 1'b1;
          cnt_d   = cnt_q - 1'b1;
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      wb_d.reg_write = reg_write_m;
      wb_d.result    = is_load ? (misalign ? '0 : ram_rdata) : alu_result_m;
      wb_d.write_reg = write_reg_m;
      wb_d.upper     = upper_m;
    end
  end

  // Reset in the commit cycle must also abort the store.
  assign ram_we = commit & is_store & ~misalign & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (commit && misalign) begin
      misalign_q <= 1'b1;
    end
  end
  assign misalign_err = misalign_q;
`endif

  data_ram #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (word_addr),
    .wdata (write_data_m),
    .rdata (ram_rdata)
  );

  assign reg_write_w = wb_q.reg_write;
  assign result_w    = wb_q.result;
  assign write_reg_w = wb_q.write_reg;
  assign upper_w     = wb_q.upper;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: self-checking bench for memory_stage.
// Three DUT instances (WAIT_STATES = 2, 0, 3) share clk/reset; one is active
// at a time, the idle ones see all-zero inputs.
`timescale 1ns/1ps
module tb_memory_stage;
  import cpu_pkg::*;

  localparam int NI        = 3;
  localparam int MEM_WORDS = 256;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  function automatic int ws_of(input int i);
    case (i)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  typedef struct packed {
    logic        rw;
    logic [31:0] res;
    logic [4:0]  wr;
    logic        up;
  } wb_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NI-1:0]       rw_m, m2r_m, mw_m, up_m;
  logic [NI-1:0][31:0] alu_m, wd_m;
  logic [NI-1:0][4:0]  wreg_m;
  logic [NI-1:0]       stall_v, rw_w, up_w;
  logic [NI-1:0][31:0] res_w;
  logic [NI-1:0][4:0]  wreg_w;
`ifdef MEM_ALIGN_CHECK_EN
  logic [NI-1:0]       mis_v;
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    memory_stage #(
      .MEM_WORDS   (MEM_WORDS),
      .WAIT_STATES (ws_of(g))
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .reg_write_m  (rw_m[g]),
      .mem_to_reg_m (m2r_m[g]),
      .mem_write_m  (mw_m[g]),
      .alu_result_m (alu_m[g]),
      .write_data_m (wd_m[g]),
      .write_reg_m  (wreg_m[g]),
      .upper_m      (up_m[g]),
      .stall_m      (stall_v[g]),
      .reg_write_w  (rw_w[g]),
      .result_w     (res_w[g]),
      .write_reg_w  (wreg_w[g]),
      .upper_w      (up_w[g])
`ifdef MEM_ALIGN_CHECK_EN
      ,
      .misalign_err (mis_v[g])
`endif
    );

    int wr_cnt = 0;
    always @(posedge clk) begin
      if (u_dut.ram_we) wr_cnt <= wr_cnt + 1;
    end
  end

  // ---------------- model / scoreboard state ----------------
  logic [31:0] mem_m [NI][MEM_WORDS];
  int          exp_wr [NI];
  logic        exp_mis [NI];
  logic        exp_q [$];   // expected stall_m, one entry per cycle
  wb_t         wb_q [$];    // expected WB register after that cycle's edge
  wb_t         wb_cur;
  int          act;
  bit          checking;
  int          n_checks;
  int          n_errors;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (checking) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL model_sync: got empty queue expected one entry");
      end else begin
        check32("stall_m", 32'(stall_v[act]), 32'(exp_q.pop_front()));
      end
      check32("reg_write_w", 32'(rw_w[act]), 32'(wb_cur.rw));
      check32("result_w", res_w[act], wb_cur.res);
      check32("write_reg_w", 32'(wreg_w[act]), 32'(wb_cur.wr));
      check32("upper_w", 32'(up_w[act]), 32'(wb_cur.up));
      if (wb_q.size() != 0) wb_cur = wb_q.pop_front();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input int inst, input bit rst, input bit rw, input bit m2r,
                       input bit mw, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] wreg, input bit up, input bit es, input wb_t ew);
    act          = inst;
    reset        = rst;
    rw_m[inst]   = rw;
    m2r_m[inst]  = m2r;
    mw_m[inst]   = mw;
    alu_m[inst]  = addr;
    wd_m[inst]   = wd;
    wreg_m[inst] = wreg;
    up_m[inst]   = up;
    exp_q.push_back(es);
    wb_q.push_back(ew);
    @(posedge clk);
    #1;
  endtask

  // One whole instruction: stalls for the wait states, then completes.
  task automatic run_op(input int inst, input bit rw, input bit m2r, input bit mw,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] wreg, input bit up);
    int  ws;
    int  idx;
    bit  mis;
    wb_t fin;
    ws  = ws_of(inst);
    idx = int'((addr >> 2) % MEM_WORDS);
    mis = ALIGN_EN && (addr[1:0] != 2'b00);
    fin = '{rw, addr, wreg, up};
    if (m2r || mw) begin
      for (int k = 0; k < ws; k++) begin
        cycle(inst, 1'b0, rw, m2r, mw, addr, wd, wreg, up, 1'b1, '0);
      end
      if (m2r) fin.res = mis ? 32'h0 : mem_m[inst][idx];
      if (mw && !m2r && !mis) begin
        mem_m[inst][idx] = wd;
        exp_wr[inst]++;
      end
      if (mis) exp_mis[inst] = 1'b1;
    end
    cycle(inst, 1'b0, rw, m2r, mw, addr, wd, wreg, up, 1'b0, fin);
  endtask

  task automatic idle(input int inst, input int n);
    for (int k = 0; k < n; k++) run_op(inst, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic reset_cycle(input int inst);
    cycle(inst, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, '0);
    for (int i = 0; i < NI; i++) exp_mis[i] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    checking = 1'b0;
    act      = 0;
    wb_cur   = '0;
    reset    = 1'b1;
    rw_m = '0; m2r_m = '0; mw_m = '0; up_m = '0;
    alu_m = '0; wd_m = '0; wreg_m = '0;
    for (int i = 0; i < NI; i++) begin
      exp_wr[i]  = 0;
      exp_mis[i] = 1'b0;
      for (int j = 0; j < MEM_WORDS; j++) mem_m[i][j] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    for (int i = 0; i < NI; i++) begin
      check32("reset_result_w", res_w[i], 32'h0);
      check32("reset_reg_write_w", 32'(rw_w[i]), 32'h0);
      check32("reset_stall_m", 32'(stall_v[i]), 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
      check32("reset_misalign_err", 32'(mis_v[i]), 32'h0);
`endif
    end

    checking = 1'b1;

    // WAIT_STATES=2: ALU op
    run_op(0, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1);
    check32("alu_result", res_w[0], 32'h1234);
    check32("alu_write_reg", 32'(wreg_w[0]), 32'd5);
    check32("alu_reg_write", 32'(rw_w[0]), 32'd1);
    check32("alu_upper", 32'(up_w[0]), 32'd1);

    // WAIT_STATES=2: store then load
    run_op(0, 1'b0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 5'd0, 1'b0);
    run_op(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd9, 1'b0);
    check32("ws2_load_data", res_w[0], 32'hDEADBEEF);
    check32("ws2_load_reg", 32'(wreg_w[0]), 32'd9);
    idle(0, 1);

    // Misaligned store to 0x22 over a known word 8, then reads
    run_op(0, 1'b0, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 5'd0, 1'b0);
    run_op(0, 1'b0, 1'b0, 1'b1, 32'h22, 32'hCAFEF00D, 5'd0, 1'b0);
    run_op(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd7, 1'b0);
    check32("word8_after_misaligned_store", res_w[0],
            ALIGN_EN ? 32'hA5A5A5A5 : 32'hCAFEF00D);
    run_op(0, 1'b1, 1'b1, 1'b0, 32'h23, 32'h0, 5'd3, 1'b0);
    check32("misaligned_load", res_w[0], ALIGN_EN ? 32'h0 : 32'hCAFEF00D);
    check32("misaligned_load_reg_write", 32'(rw_w[0]), 32'd1);
    idle(0, 3);
`ifdef MEM_ALIGN_CHECK_EN
    check32("misalign_err_sticky", 32'(mis_v[0]), 32'(exp_mis[0]));
    check32("misalign_err_set", 32'(mis_v[0]), 32'd1);
`endif
    reset_cycle(0);
`ifdef MEM_ALIGN_CHECK_EN
    check32("misalign_err_cleared", 32'(mis_v[0]), 32'd0);
`endif

    // Load and store both set: behaves as a load, RAM untouched
    run_op(0, 1'b0, 1'b0, 1'b1, 32'h30, 32'h0BADCAFE, 5'd0, 1'b0);
    run_op(0, 1'b1, 1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, 5'd2, 1'b0);
    check32("both_flags_load", res_w[0], 32'h0BADCAFE);
    run_op(0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 5'd2, 1'b0);
    check32("both_flags_ram_unchanged", res_w[0], 32'h0BADCAFE);
    idle(0, 1);

    // WAIT_STATES=0: store/load and address aliasing
    run_op(1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h13579BDF, 5'd0, 1'b0);
    run_op(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd4, 1'b1);
    check32("ws0_load", res_w[1], 32'h13579BDF);
    run_op(1, 1'b1, 1'b1, 1'b0, 32'h410, 32'h0, 5'd6, 1'b0);
    check32("ws0_alias_load", res_w[1], 32'h13579BDF);
    idle(1, 1);

    // WAIT_STATES=3: store aborted by reset on the second ACCESS cycle
    run_op(2, 1'b0, 1'b0, 1'b1, 32'h20, 32'h11111111, 5'd0, 1'b0);
    idle(2, 1);
    cycle(2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h55, 5'd8, 1'b1, 1'b1, '0);
    cycle(2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h55, 5'd8, 1'b1, 1'b1, '0);
    cycle(2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h55, 5'd8, 1'b1, 1'b1, '0);
    for (int i = 0; i < NI; i++) exp_mis[i] = 1'b0;
    check32("abort_result_zero", res_w[2], 32'h0);
    check32("abort_reg_write_zero", 32'(rw_w[2]), 32'h0);
    idle(2, 2);
    run_op(2, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd1, 1'b0);
    check32("abort_store_not_committed", res_w[2], 32'h11111111);
    idle(2, 1);

    checking = 1'b0;

    // RAM write counts
    check32("wr_count_ws2", 32'(g_dut[0].wr_cnt), 32'(exp_wr[0]));
    check32("wr_count_ws0", 32'(g_dut[1].wr_cnt), 32'(exp_wr[1]));
    check32("wr_count_ws3", 32'(g_dut[2].wr_cnt), 32'(exp_wr[2]));
    check32("wr_count_ws0_literal", 32'(g_dut[1].wr_cnt), 32'd1);
    check32("wr_count_ws3_literal", 32'(g_dut[2].wr_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
